// File: rtl/ryu_jump_controller.sv
// ryu_jump_controller
// ---------------------------------------------------------------------------
// Jump controller and sprite-sheet address generator for the Ryu jump sprite.
// Once per video frame (rising edge of vs) a rise/fall/land state machine
// advances the sprite height and animation frame. Every pixel clock the
// current DrawX/DrawY is mapped to a sprite-sheet ROM address plus a hit
// flag. Both are registered, with one cycle of latency.
//
// Build option:
//   RYU_JUMP_BUFFER_EN - when defined, a jump_req seen during LAND is
//                        remembered. LAND then exits straight into a new
//                        RISE instead of passing through IDLE.
//
// Ports:
//   vga_clk      in   pixel clock (only clock)
//   reset_n      in   asynchronous active-low reset
//   DrawX/DrawY  in   current pixel coordinates (10 bits each)
//   blank        in   high while in the active display region
//   vs           in   vertical sync, synchronous to vga_clk
//   jump_req     in   level jump request
//   sprite_y     out  sprite top row
//   anim_frame   out  animation frame index 0..5
//   busy         out  high whenever the state is not IDLE
//   rom_address  out  sprite-sheet ROM address (0 when not hit)
//   sprite_hit   out  current pixel lies inside the sprite box
// ---------------------------------------------------------------------------
module ryu_jump_controller #(
    parameter int SPRITE_W    = 54,
    parameter int SPRITE_H    = 77,
    parameter int SPRITE_X    = 300,
    parameter int GROUND_Y    = 400,
    parameter int JUMP_V      = 12,
    parameter int LAND_FRAMES = 4,
    parameter int ADDR_W      = 15
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              vs,
    input  logic              jump_req,
    output logic [9:0]        sprite_y,
    output logic [2:0]        anim_frame,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_hit
);

    localparam int V_W   = 8;
    localparam int CNT_W = $clog2(LAND_FRAMES + 1);

    localparam logic [9:0]        Y_REST     = 10'(GROUND_Y - SPRITE_H);
    localparam logic [V_W-1:0]    V_START    = V_W'(JUMP_V);
    localparam logic [V_W-1:0]    V_HALF     = V_W'(JUMP_V / 2);
    localparam logic [CNT_W-1:0]  LAND_START = CNT_W'(LAND_FRAMES);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPRITE_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_LAND = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic [CNT_W-1:0]  land_cnt_q, land_cnt_d;
    logic              pending_q, pending_d;
    logic              vs_q;
    logic [9:0]        sprite_y_q, sprite_y_d;
    logic [2:0]        anim_q, anim_d;
    logic              tick;

    logic [10:0]       rel_x, rel_y;
    logic              hit_d, hit_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] frame_base, row_off;

    // vs_q resets high so a vs held high through reset does not fire a tick.
    assign tick = vs & ~vs_q;

    // ---------------------------------------------------------------------
    // Frame state machine: register
    // ---------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            v_q        <= '0;
            land_cnt_q <= '0;
            pending_q  <= 1'b0;
            vs_q       <= 1'b1;
            sprite_y_q <= Y_REST;
            anim_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            land_cnt_q <= land_cnt_d;
            pending_q  <= pending_d;
            vs_q       <= vs;
            sprite_y_q <= sprite_y_d;
            anim_q     <= anim_d;
        end
    end

    // ---------------------------------------------------------------------
    // Frame state machine: next state and next outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        land_cnt_d = land_cnt_q;
        pending_d  = pending_q;

        // Requests are latched between ticks so a short pulse is not lost.
        if (state_q == ST_IDLE && jump_req) begin
            pending_d = 1'b1;
        end
`ifdef RYU_JUMP_BUFFER_EN
        if (state_q == ST_LAND && jump_req) begin
            pending_d = 1'b1;
        end
`endif

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A request on the tick itself starts immediately.
                    if (pending_q || jump_req) begin
                        state_d   = ST_RISE;
                        v_d       = V_START;
                        h_d       = '0;
                        pending_d = 1'b0;
                    end
                end
                ST_RISE: begin
                    h_d = h_q + 10'(v_q);
                    v_d = v_q - V_W'(1);
                    if (v_d == '0) begin
                        state_d = ST_FALL;
                    end
                end
                ST_FALL: begin
                    v_d = v_q + V_W'(1);
                    if (h_q <= 10'(v_d)) begin
                        h_d        = '0;
                        state_d    = ST_LAND;
                        land_cnt_d = LAND_START;
                    end else begin
                        h_d = h_q - 10'(v_d);
                    end
                end
                ST_LAND: begin
                    land_cnt_d = land_cnt_q - CNT_W'(1);
                    if (land_cnt_d == '0) begin
`ifdef RYU_JUMP_BUFFER_EN
                        if (pending_q || jump_req) begin
                            state_d   = ST_RISE;
                            v_d       = V_START;
                            h_d       = '0;
                            pending_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            v_d     = '0;
                        end
`else
                        state_d = ST_IDLE;
                        v_d     = '0;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Output registers are loaded from the post-tick values so they are
        // stable for the whole following frame.
        sprite_y_d = Y_REST - h_d;
        anim_d     = 3'd0;
        unique case (state_d)
            ST_RISE: anim_d = (v_d > V_HALF) ? 3'd1 : 3'd2;
            ST_FALL: anim_d = (v_d < V_HALF) ? 3'd3 : 3'd4;
            ST_LAND: anim_d = 3'd5;
            default: anim_d = 3'd0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Pixel address path (one cycle latency)
    // ---------------------------------------------------------------------
    always_comb begin
        // 11-bit two's complement offsets; bit 10 set means left of / above
        // the sprite box.
        rel_x = {1'b0, DrawX} - 11'(SPRITE_X);
        rel_y = {1'b0, DrawY} - {1'b0, sprite_y_q};
        hit_d = blank
                && !rel_x[10] && (rel_x < 11'(SPRITE_W))
                && !rel_y[10] && (rel_y < 11'(SPRITE_H));
        frame_base = ADDR_W'(anim_q) * FRAME_SIZE;
        row_off    = ADDR_W'(rel_y) * ROW_SIZE;
        addr_d     = hit_d ? (frame_base + row_off + ADDR_W'(rel_x)) : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign sprite_y    = sprite_y_q;
    assign anim_frame  = anim_q;
    assign busy        = (state_q != ST_IDLE);
    assign rom_address = addr_q;
    assign sprite_hit  = hit_q;

endmodule

// File: tb/tb_ryu_jump_controller.sv
// Directed testbench for ryu_jump_controller: reset values, pixel address
// mapping, full jump trajectory, held request, mid-fall reset and the
// LAND request behaviour (both builds of RYU_JUMP_BUFFER_EN).
module tb_ryu_jump_controller;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank, vs, jump_req;
    logic [9:0]  sprite_y;
    logic [2:0]  anim_frame;
    logic        busy;
    logic [14:0] rom_address;
    logic        sprite_hit;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed trajectory for JUMP_V=12; index = tick number, tick 0
    // being the tick that leaves IDLE.
    int exp_y [31] = '{323, 311, 300, 290, 281, 273, 266, 260, 255, 251, 248,
                       246, 245, 246, 248, 251, 255, 260, 266, 273, 281, 290,
                       300, 311, 323, 323, 323, 323, 323, 323, 323};
    int exp_a [31] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3,
                       4, 4, 4, 4, 4, 4, 5, 5, 5, 5, 0, 0, 0};

    ryu_jump_controller dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .vs          (vs),
        .jump_req    (jump_req),
        .sprite_y    (sprite_y),
        .anim_frame  (anim_frame),
        .busy        (busy),
        .rom_address (rom_address),
        .sprite_hit  (sprite_hit)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; jump_req takes the given level together with vs rising.
    task automatic frame_tick(input logic req);
        @(negedge vga_clk);
        vs       = 1'b1;
        jump_req = req;
        @(negedge vga_clk);
        vs = 1'b0;
    endtask

    // One-cycle request pulse between ticks.
    task automatic req_pulse();
        @(negedge vga_clk);
        jump_req = 1'b1;
        @(negedge vga_clk);
        jump_req = 1'b0;
    endtask

    // Drive one pixel and check the registered result one cycle later.
    task automatic pix(input string tag, input int x, input int y, input logic b,
                       input logic exp_hit, input int exp_addr);
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(negedge vga_clk);
        check({tag, "_hit"}, 32'(sprite_hit), 32'(exp_hit));
        check({tag, "_addr"}, 32'(rom_address), 32'(exp_addr));
        $display("pix %s x=%0d y=%0d blank=%0d -> hit=%0d addr=%0d",
                 tag, x, y, b, sprite_hit, rom_address);
    endtask

    task automatic check_tick(input string tag, input int t);
        check($sformatf("%s_y_t%0d", tag, t), 32'(sprite_y), 32'(exp_y[t]));
        check($sformatf("%s_anim_t%0d", tag, t), 32'(anim_frame), 32'(exp_a[t]));
        check($sformatf("%s_busy_t%0d", tag, t), 32'(busy), (t < 28) ? 32'd1 : 32'd0);
        $display("tick %s t=%0d sprite_y=%0d anim=%0d busy=%0d",
                 tag, t, sprite_y, anim_frame, busy);
    endtask

    initial begin
        reset_n  = 1'b1;
        DrawX    = '0;
        DrawY    = '0;
        blank    = 1'b0;
        vs       = 1'b0;
        jump_req = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);

        // Reset values
        check("rst_y", 32'(sprite_y), 32'd323);
        check("rst_anim", 32'(anim_frame), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hit", 32'(sprite_hit), 32'd0);
        check("rst_addr", 32'(rom_address), 32'd0);
        reset_n = 1'b1;

        // Idle scan (sprite_y=323, frame 0)
        pix("idle_tl", 300, 323, 1'b1, 1'b1, 0);
        pix("idle_br", 353, 399, 1'b1, 1'b1, 4157);
        pix("idle_xr", 354, 399, 1'b1, 1'b0, 0);
        pix("idle_xl", 299, 323, 1'b1, 1'b0, 0);
        pix("idle_ya", 300, 322, 1'b1, 1'b0, 0);
        pix("idle_yb", 300, 400, 1'b1, 1'b0, 0);
        pix("idle_blank", 320, 350, 1'b0, 1'b0, 0);
        pix("idle_mid", 320, 350, 1'b1, 1'b1, 1478);

        // A: single-cycle request in IDLE, full trajectory plus two idle ticks
        req_pulse();
        for (int t = 0; t <= 30; t++) begin
            frame_tick(1'b0);
            check_tick("A", t);
        end

        // B: request coincident with the tick, held through RISE
        for (int t = 0; t <= 29; t++) begin
            frame_tick((t <= 12) ? 1'b1 : 1'b0);
            check_tick("B", t);
            if (t == 6) begin
                pix("rise_f2_00", 300, 266, 1'b1, 1'b1, 8316);
                pix("rise_f2_11", 301, 267, 1'b1, 1'b1, 8371);
            end
        end

        // D: reset in the middle of FALL
        req_pulse();
        for (int t = 0; t <= 15; t++) begin
            frame_tick(1'b0);
        end
        check_tick("D", 15);
        pix("fall_pix", 310, 260, 1'b1, 1'b1, 12970);
        @(posedge vga_clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_y", 32'(sprite_y), 32'd323);
        check("arst_anim", 32'(anim_frame), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hit", 32'(sprite_hit), 32'd0);
        check("arst_addr", 32'(rom_address), 32'd0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
        pix("post_rst_pix", 310, 260, 1'b1, 1'b0, 0);
        frame_tick(1'b0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_y", 32'(sprite_y), 32'd323);

        // C: request pulsed during LAND
        req_pulse();
        for (int t = 0; t <= 24; t++) begin
            frame_tick(1'b0);
        end
        check_tick("C", 24);
        req_pulse();
        for (int t = 25; t <= 27; t++) begin
            frame_tick(1'b0);
            check_tick("C", t);
        end
        frame_tick(1'b0);
`ifdef RYU_JUMP_BUFFER_EN
        check("land_exit_anim", 32'(anim_frame), 32'd1);
        check("land_exit_busy", 32'(busy), 32'd1);
        check("land_exit_y", 32'(sprite_y), 32'd323);
        frame_tick(1'b0);
        check("rejump_y", 32'(sprite_y), 32'd311);
        check("rejump_busy", 32'(busy), 32'd1);
`else
        check("land_exit_anim", 32'(anim_frame), 32'd0);
        check("land_exit_busy", 32'(busy), 32'd0);
        check("land_exit_y", 32'(sprite_y), 32'd323);
        frame_tick(1'b0);
        check("no_rejump_y", 32'(sprite_y), 32'd323);
        check("no_rejump_busy", 32'(busy), 32'd0);
`endif
        $display("land-exit step sprite_y=%0d anim=%0d busy=%0d", sprite_y, anim_frame, busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
